// File: rtl/accel_arb_pkg.sv
// accel_arb_pkg
//   Shared types and constants for the accelerator memory arbiter.
//   - arb_state_t           : arbiter FSM states (IDLE, GRANT)
//   - ACCEL_ARB_NREQ_DEF    : default number of requesters
//   - ACCEL_ARB_TIMEOUT_DEF : default stall budget (cycles) before abort
//   - accel_arb_clog2()     : ceil(log2(value)), used for index and counter widths
package accel_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ACCEL_ARB_NREQ_DEF    = 32'sd4;
  localparam int ACCEL_ARB_TIMEOUT_DEF = 32'sd1024;

  function automatic int accel_arb_clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/accel_rr_picker.sv
// accel_rr_picker
//   Combinational round-robin find-first. Searches the request vector in the
//   order last+1, last+2, ... (modulo N_REQ) and returns the first set index.
// Ports:
//   i_req  [N_REQ-1:0] : active request bits
//   i_last [ID_W-1:0]  : most recently served requester
//   o_idx  [ID_W-1:0]  : winning requester (0 when none)
//   o_any              : at least one request is active
module accel_rr_picker
  import accel_arb_pkg::*;
#(
  parameter int N_REQ = ACCEL_ARB_NREQ_DEF,
  parameter int ID_W  = accel_arb_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int w_cand;

  // Walk the offsets from farthest to nearest so the nearest active
  // requester after i_last is the one left in o_idx.
  always_comb begin
    o_idx  = {ID_W{1'b0}};
    o_any  = 1'b0;
    w_cand = 32'sd0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = (int'(i_last) + k) % N_REQ;
      o_any  = o_any | i_req[w_cand];
      o_idx  = i_req[w_cand] ? ID_W'(w_cand) : o_idx;
    end
  end

endmodule

// File: rtl/accel_mem_arbiter.sv
// accel_mem_arbiter
//   Shares one Avalon-MM master port (avm_ACCEL_*) among N_REQ accelerator
//   requesters with round-robin arbitration, one transfer in flight at a time.
//   Each transfer costs one arbitration cycle (IDLE) plus one or more transfer
//   cycles (GRANT). Command outputs are combinational from the registered
//   state/grant and the granted requester's inputs.
// Optional feature: ACCEL_ARB_TIMEOUT_EN
//   When defined, a GRANT stalled for TIMEOUT cycles is aborted: the requester
//   is released with zero read data and the sticky arb_err/arb_err_id record it.
//   When undefined, GRANT waits indefinitely and arb_err/arb_err_id are 0.
// Ports:
//   csi_clockreset_clk     : clock
//   csi_clockreset_reset_n : synchronous active-low reset
//   req_address/writedata/byteenable/read/write : per-requester command (sliced)
//   req_waitrequest        : per-requester, low in the acceptance cycle
//   req_readdata           : broadcast read data
//   avm_ACCEL_*            : master command / response
//   arb_err, arb_err_id    : sticky timeout flag and offending requester
module accel_mem_arbiter
  import accel_arb_pkg::*;
#(
  parameter int N_REQ   = ACCEL_ARB_NREQ_DEF,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = ACCEL_ARB_TIMEOUT_DEF
) (
  input  logic                              csi_clockreset_clk,
  input  logic                              csi_clockreset_reset_n,
  input  logic [N_REQ*ADDR_W-1:0]           req_address,
  input  logic [N_REQ*64-1:0]               req_writedata,
  input  logic [N_REQ*8-1:0]                req_byteenable,
  input  logic [N_REQ-1:0]                  req_read,
  input  logic [N_REQ-1:0]                  req_write,
  output logic [N_REQ-1:0]                  req_waitrequest,
  output logic [63:0]                       req_readdata,
  output logic [ADDR_W-1:0]                 avm_ACCEL_address,
  output logic [63:0]                       avm_ACCEL_writedata,
  output logic [7:0]                        avm_ACCEL_byteenable,
  output logic                              avm_ACCEL_read,
  output logic                              avm_ACCEL_write,
  input  logic [63:0]                       avm_ACCEL_readdata,
  input  logic                              avm_ACCEL_waitrequest,
  output logic                              arb_err,
  output logic [accel_arb_clog2(N_REQ)-1:0] arb_err_id
);

  localparam int ID_W = accel_arb_clog2(N_REQ);

  // Elaboration-time parameter range check.
  if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT < 2)) begin : g_param_check
    $error("accel_mem_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_grant_nxt;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   w_last_nxt;
  logic [ID_W-1:0]   w_pick;
  logic              w_any;
  logic [N_REQ-1:0]  w_req_any;
  logic              w_g_rd;
  logic              w_g_wr;
  logic              w_g_active;
  logic [ADDR_W-1:0] w_g_addr;
  logic [63:0]       w_g_wdata;
  logic [7:0]        w_g_be;
  logic              w_in_grant;
  logic              w_accept;
  logic              w_drop;
  logic              w_tmo_hit;

  assign w_req_any = req_read | req_write;

  accel_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .i_req  (w_req_any),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // Granted requester's command. A simultaneous read+write forwards only
  // the write; the requester has to re-issue the read.
  assign w_g_wr     = req_write[r_grant];
  assign w_g_rd     = req_read[r_grant] & ~req_write[r_grant];
  assign w_g_active = w_g_rd | w_g_wr;
  assign w_g_addr   = req_address[int'(r_grant)*ADDR_W +: ADDR_W];
  assign w_g_wdata  = req_writedata[int'(r_grant)*64 +: 64];
  assign w_g_be     = req_byteenable[int'(r_grant)*8 +: 8];

  assign w_in_grant = (r_state == GRANT);
  assign w_accept   = w_in_grant & w_g_active & ~avm_ACCEL_waitrequest;
  // Strobes dropped before acceptance: release the grant, nothing issued.
  assign w_drop     = w_in_grant & ~w_g_active;

`ifdef ACCEL_ARB_TIMEOUT_EN
  localparam int              TMO_W    = accel_arb_clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_arb_err;
  logic [ID_W-1:0]  r_arb_err_id;

  assign w_tmo_hit = w_in_grant & w_g_active & avm_ACCEL_waitrequest &
                     (r_tmo_cnt == TMO_LAST);

  // Stall counter (held at zero outside GRANT) and sticky error record.
  always_ff @(posedge csi_clockreset_clk) begin
    if (!csi_clockreset_reset_n) begin
      r_tmo_cnt    <= {TMO_W{1'b0}};
      r_arb_err    <= 1'b0;
      r_arb_err_id <= {ID_W{1'b0}};
    end else begin
      if (!w_in_grant) begin
        r_tmo_cnt <= {TMO_W{1'b0}};
      end else if (avm_ACCEL_waitrequest) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
      if (w_tmo_hit) begin
        r_arb_err    <= 1'b1;
        r_arb_err_id <= r_grant;
      end else begin
        r_arb_err    <= r_arb_err;
        r_arb_err_id <= r_arb_err_id;
      end
    end
  end

  // The abort cycle already reports the error so the requester sees it
  // alongside its forced release.
  assign arb_err    = r_arb_err | w_tmo_hit;
  assign arb_err_id = w_tmo_hit ? r_grant : r_arb_err_id;
`else
  assign w_tmo_hit  = 1'b0;
  assign arb_err    = 1'b0;
  assign arb_err_id = {ID_W{1'b0}};
`endif

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge csi_clockreset_clk) begin
    if (!csi_clockreset_reset_n) begin
      r_state <= IDLE;
      r_grant <= {ID_W{1'b0}};
      r_last  <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic and the master/requester output mux.
  always_comb begin
    w_state_nxt          = r_state;
    w_grant_nxt          = r_grant;
    w_last_nxt           = r_last;
    avm_ACCEL_read       = 1'b0;
    avm_ACCEL_write      = 1'b0;
    avm_ACCEL_address    = {ADDR_W{1'b0}};
    avm_ACCEL_writedata  = 64'h0;
    avm_ACCEL_byteenable = 8'h0;
    req_waitrequest      = {N_REQ{1'b1}};
    req_readdata         = 64'h0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        avm_ACCEL_read       = w_g_rd;
        avm_ACCEL_write      = w_g_wr;
        avm_ACCEL_address    = w_g_active ? w_g_addr  : {ADDR_W{1'b0}};
        avm_ACCEL_writedata  = w_g_active ? w_g_wdata : 64'h0;
        avm_ACCEL_byteenable = w_g_active ? w_g_be    : 8'h0;
        if (w_tmo_hit) begin
          req_waitrequest[r_grant] = 1'b0;
          req_readdata             = 64'h0;
        end else begin
          req_waitrequest[r_grant] = avm_ACCEL_waitrequest;
          req_readdata             = avm_ACCEL_readdata;
        end
        if (w_accept || w_drop || w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/accel_mem_arbiter.md
# accel_mem_arbiter

Shares the single Avalon-MM memory master port (`avm_ACCEL_*`, 32-bit address, 64-bit data, 8-bit byteenable) among `N_REQ` accelerator instances. Each requester keeps the already-unpacked address/writedata/byteenable form that the accelerator wrappers produce. Arbitration is round-robin, and one transfer is granted at a time. The block sits between the accelerator wrappers and the on-chip memory / PCIe bridge fabric.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 1024: stall cycles before abort. Used only with `ACCEL_ARB_TIMEOUT_EN`.
- `csi_clockreset_clk` in 1: the single clock.
- `csi_clockreset_reset_n` in 1: reset, synchronous, active-low.
- `req_address` in `N_REQ*ADDR_W`: requester `i` occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_writedata` in `N_REQ*64`: per-requester write data, already byte-lane shifted.
- `req_byteenable` in `N_REQ*8`: per-requester byte enables.
- `req_read`, `req_write` in `N_REQ`: request strobes, held high until accepted.
- `req_waitrequest` out `N_REQ`: low marks acceptance of requester `i`'s transfer in that cycle.
- `req_readdata` out 64: broadcast read data, valid for requester `i` only in its acceptance cycle.
- `avm_ACCEL_address` out `ADDR_W`; `avm_ACCEL_writedata` out 64; `avm_ACCEL_byteenable` out 8; `avm_ACCEL_read`, `avm_ACCEL_write` out 1: master command.
- `avm_ACCEL_readdata` in 64; `avm_ACCEL_waitrequest` in 1: master response.
- `arb_err` out 1: sticky timeout flag.
- `arb_err_id` out `clog2(N_REQ)`: requester that timed out.

## Operation
- State `IDLE`:
  - If any `req_read|req_write` bit is set, pick the first active requester in the order `last+1, last+2, …` modulo `N_REQ`.
  - Register it in `grant`, then go to `GRANT`.
  - `last` resets to `N_REQ-1`, so requester 0 wins the first contest.
- State `GRANT`:
  - The `avm_ACCEL_*` command outputs are a mux of requester `grant`, gated by its strobes.
  - `req_waitrequest[grant] = avm_ACCEL_waitrequest`. Every other bit is 1.
  - `req_readdata = avm_ACCEL_readdata`.
- Acceptance: when the granted strobe is high and `avm_ACCEL_waitrequest=0`, the transfer completes that cycle. Then `last<=grant` and the state goes to `IDLE`.
- Granted requester drops both strobes before acceptance (protocol violation): return to `IDLE` and set `last<=grant`. No transfer is issued.
- `req_read` and `req_write` both high from one requester: the write is forwarded and the read is masked (`avm_ACCEL_read=0`). The requester must re-issue the read.
- In `IDLE`:
  - All `avm_ACCEL_*` command outputs are 0.
  - All `req_waitrequest` bits are 1.
- Request arrival in the same cycle as an acceptance: not considered until the next `IDLE` cycle. There is no grant chaining.

## Timing
- Reset values:
  - `avm_ACCEL_read`, `avm_ACCEL_write`, `avm_ACCEL_address`, `avm_ACCEL_writedata`, `avm_ACCEL_byteenable` = 0.
  - `req_waitrequest` = all 1s.
  - `arb_err` = 0; `arb_err_id` = 0.
  - `state` = `IDLE`; `last` = `N_REQ-1`.
- Latency: a request rising at edge *k* appears on the master at cycle *k+1*. With a zero-wait slave it is accepted in *k+1*.
- Throughput: one transfer per 2 cycles per port (1 arbitration cycle + ≥1 transfer cycle).
- Fairness: a continuously requesting agent waits at most `N_REQ-1` transfers.
- Master command outputs are combinational from registered `grant` and `state` plus the requester inputs.
- Reset asserted mid-transfer: at the next edge the state returns to `IDLE` and the master strobes drop. The in-flight transfer is abandoned and `arb_err` clears.

## Configuration
- `ACCEL_ARB_TIMEOUT_EN` defined:
  - A counter runs in `GRANT` while `avm_ACCEL_waitrequest=1`. It is cleared on each entry to `GRANT`.
  - On reaching `TIMEOUT-1`: set `arb_err`, set `arb_err_id<=grant`, and force `req_waitrequest[grant]=0` with `req_readdata=0` for one cycle.
  - Then `last<=grant` and the state goes to `IDLE`.
  - `arb_err` clears only on reset.
- Not defined: no counter; `GRANT` waits indefinitely; `arb_err` and `arb_err_id` are tied 0.

## Structure
- Package `accel_arb_pkg` holds:
  - the state enum `arb_state_t` {`IDLE`, `GRANT`};
  - the defaults `ACCEL_ARB_NREQ_DEF` and `ACCEL_ARB_TIMEOUT_DEF`;
  - the clog2 helper.
- Sub-module `accel_rr_picker`: combinational round-robin find-first. Inputs are the request vector and `last`; outputs are the grant index and `any`.
- The arbiter FSM, grant register, output mux and timeout counter live in the top level.

## Test plan
- Single write: requester 2 writes addr 0x100, data 0x1122334455667788, BE 0xFF, zero-wait slave. Expect the master to show exactly that transfer one cycle after the request and `req_waitrequest[2]` low for one cycle.
- Contention: requesters 0–3 all read at once, slave waitrequest 0. Expect grants in order 0,1,2,3, each with 1-cycle waitrequest low, and 8 cycles total.
- Fairness: requester 0 requests continuously, requester 1 requests once. Expect requester 1 granted immediately after requester 0's current transfer.
- Stall: slave holds waitrequest high for 5 cycles on requester 1's read returning 0xA5A5A5A5A5A5A5A5. Expect `req_waitrequest[1]` high for 5 cycles, then low with that readdata; other requesters stay waited.
- Timeout, `ACCEL_ARB_TIMEOUT_EN` with `TIMEOUT=16`: slave never acknowledges requester 3. Expect at stall cycle 16 `req_waitrequest[3]=0`, `req_readdata=0`, `arb_err=1` and `arb_err_id=3`, followed by a return to `IDLE`.
- Reset mid-`GRANT`: assert `csi_clockreset_reset_n=0` during a stalled write. Expect `avm_ACCEL_write=0` at the next edge and all outputs at their reset values.
